// File: rtl/hashcore_pkg.sv
// Shared hash-core types and constants for the nonce path.
// Pure declarations: no logic, no latency, no flow control.
package hashcore_pkg;

    localparam int DEFAULT_PIPE_DEPTH = 32;
    localparam int NONCE_W            = 32;

    typedef logic [NONCE_W-1:0] nonce_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/nonce_sequencer_if.sv
// Core-side nonce/match pair plus the golden-nonce valid/ready drain.
// master = sequencer, slave = core and comms front end.
interface nonce_sequencer_if;
    import hashcore_pkg::*;

    nonce_t nonce_out;
    logic   gn_match;
    nonce_t gn_data;
    logic   gn_valid;
    logic   gn_ready;

    modport master (
        output nonce_out,
        output gn_data,
        output gn_valid,
        input  gn_match,
        input  gn_ready
    );

    modport slave (
        input  nonce_out,
        input  gn_data,
        input  gn_valid,
        output gn_match,
        output gn_ready
    );

endinterface

// File: rtl/gn_fifo.sv
// Synchronous FIFO, registered write, head visible one cycle after push (no fall-through).
// Backpressure: push while full is dropped unless a pop frees the slot in the same cycle.
module gn_fifo
    import hashcore_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = clog2(DEPTH),
    localparam int CW    = clog2(DEPTH + 1)
) (
    input  logic             hash_clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    // Empty head reads as zero so the drain port never shows stale data.
    assign pop_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge hash_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/nonce_sequencer.sv
// Nonce counter for a fixed-depth hash pipeline; back-maps match flags to nonces into a FIFO.
// Capture visible one cycle after the match; FIFO full drops the capture and sets gn_overflow.
module nonce_sequencer
    import hashcore_pkg::*;
#(
    parameter  int PREFIX_W      = 3,
    parameter  int PIPE_DEPTH    = DEFAULT_PIPE_DEPTH,
    parameter  int NONCE_STRIDE  = 1,
    parameter  int GN_FIFO_DEPTH = 4,
    parameter  int STOP_ON_WRAP  = 0,
    localparam int CNT_W         = NONCE_W - PREFIX_W,
    localparam int PFX_PORT_W    = (PREFIX_W > 0) ? PREFIX_W : 1,
    localparam int GC_W          = clog2(GN_FIFO_DEPTH + 1),
    localparam int FILL_W        = clog2(PIPE_DEPTH + 1)
) (
    input  logic                  hash_clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  load,
    input  nonce_t                load_nonce,
    input  logic [PFX_PORT_W-1:0] nonce_prefix,
    nonce_sequencer_if.master     bus,
    output logic [GC_W-1:0]       gn_count,
    output logic                  gn_strobe,
    output logic                  gn_overflow,
    output logic                  wrapped,
    output logic                  primed
);

    localparam logic [CNT_W-1:0] STEP = CNT_W'(NONCE_STRIDE);
    localparam logic [CNT_W-1:0] BACK = CNT_W'(PIPE_DEPTH * NONCE_STRIDE);

    logic [CNT_W-1:0]  cnt;
    logic [FILL_W-1:0] fill;
    logic              halt;
    logic [CNT_W:0]    cnt_sum;
    logic              advance;
    logic              capture;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    nonce_t            cand;
    logic              unused_bits;

    assign cnt_sum  = {1'b0, cnt} + {1'b0, STEP};
    assign advance  = enable & ~halt & ~load;
    assign primed   = (fill == FILL_W'(PIPE_DEPTH));
    assign capture  = primed & bus.gn_match & ~load;
    assign fifo_pop = bus.gn_ready & ~fifo_empty;

    // The match belongs to the nonce issued PIPE_DEPTH advances ago; fill guarantees
    // those advances were consecutive, so plain subtraction recovers it.
    generate
        if (PREFIX_W > 0) begin : g_pfx
            assign bus.nonce_out = {nonce_prefix, cnt};
            assign cand          = {nonce_prefix, cnt - BACK};
            assign unused_bits   = ^load_nonce[NONCE_W-1:CNT_W];
        end else begin : g_nopfx
            assign bus.nonce_out = cnt;
            assign cand          = cnt - BACK;
            assign unused_bits   = nonce_prefix[0];
        end
    endgenerate

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            fill        <= '0;
            halt        <= 1'b0;
            wrapped     <= 1'b0;
            gn_overflow <= 1'b0;
            gn_strobe   <= 1'b0;
        end else begin
            gn_strobe <= capture;
            if (capture && fifo_full && !fifo_pop) begin
                gn_overflow <= 1'b1;
            end
            if (load) begin
                cnt         <= load_nonce[CNT_W-1:0];
                fill        <= '0;
                halt        <= 1'b0;
                wrapped     <= 1'b0;
                gn_overflow <= 1'b0;
            end else if (advance) begin
                cnt <= cnt_sum[CNT_W-1:0];
                if (cnt_sum[CNT_W]) begin
                    wrapped <= 1'b1;
                end
                // Halting on wrap leaves the pipeline unmappable, same as a pause.
                if (cnt_sum[CNT_W] && STOP_ON_WRAP != 0) begin
                    halt <= 1'b1;
                    fill <= '0;
                end else if (fill != FILL_W'(PIPE_DEPTH)) begin
                    fill <= fill + FILL_W'(1);
                end
            end else begin
                fill <= '0;
            end
        end
    end

    gn_fifo #(
        .WIDTH (NONCE_W),
        .DEPTH (GN_FIFO_DEPTH)
    ) u_gn_fifo (
        .hash_clk (hash_clk),
        .reset_n  (reset_n),
        .push     (capture),
        .push_dat (cand),
        .pop      (bus.gn_ready),
        .pop_dat  (bus.gn_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (gn_count)
    );

    assign bus.gn_valid = ~fifo_empty;

endmodule

// File: tb/tb_nonce_sequencer.sv
// Three sequencer configurations driven in lockstep and checked every cycle
// against a history-based model of "which nonce was issued PIPE_DEPTH advances ago".
module tb_nonce_sequencer;
    import hashcore_pkg::*;

    logic   hash_clk = 1'b0;
    logic   reset_n;
    logic   enable;
    logic   load;
    nonce_t load_nonce;
    logic   gn_match;
    logic   gn_ready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 hash_clk = ~hash_clk;

    nonce_sequencer_if bus_a ();
    nonce_sequencer_if bus_b ();
    nonce_sequencer_if bus_c ();

    assign bus_a.gn_match = gn_match;
    assign bus_b.gn_match = gn_match;
    assign bus_c.gn_match = gn_match;
    assign bus_a.gn_ready = gn_ready;
    assign bus_b.gn_ready = gn_ready;
    assign bus_c.gn_ready = gn_ready;

    logic [31:0] o_nonce  [3];
    logic [31:0] o_data   [3];
    logic        o_valid  [3];
    logic [2:0]  o_count  [3];
    logic        o_strobe [3];
    logic        o_ovf    [3];
    logic        o_wrap   [3];
    logic        o_primed [3];

    assign o_nonce[0] = bus_a.nonce_out;
    assign o_nonce[1] = bus_b.nonce_out;
    assign o_nonce[2] = bus_c.nonce_out;
    assign o_data[0]  = bus_a.gn_data;
    assign o_data[1]  = bus_b.gn_data;
    assign o_data[2]  = bus_c.gn_data;
    assign o_valid[0] = bus_a.gn_valid;
    assign o_valid[1] = bus_b.gn_valid;
    assign o_valid[2] = bus_c.gn_valid;

    nonce_sequencer #(.PREFIX_W(3), .PIPE_DEPTH(32), .NONCE_STRIDE(1), .GN_FIFO_DEPTH(4), .STOP_ON_WRAP(0)) u_dut_a (
        .hash_clk(hash_clk), .reset_n(reset_n), .enable(enable), .load(load), .load_nonce(load_nonce),
        .nonce_prefix(3'b101), .bus(bus_a), .gn_count(o_count[0]), .gn_strobe(o_strobe[0]),
        .gn_overflow(o_ovf[0]), .wrapped(o_wrap[0]), .primed(o_primed[0]));

    nonce_sequencer #(.PREFIX_W(3), .PIPE_DEPTH(8), .NONCE_STRIDE(4), .GN_FIFO_DEPTH(4), .STOP_ON_WRAP(0)) u_dut_b (
        .hash_clk(hash_clk), .reset_n(reset_n), .enable(enable), .load(load), .load_nonce(load_nonce),
        .nonce_prefix(3'b101), .bus(bus_b), .gn_count(o_count[1]), .gn_strobe(o_strobe[1]),
        .gn_overflow(o_ovf[1]), .wrapped(o_wrap[1]), .primed(o_primed[1]));

    nonce_sequencer #(.PREFIX_W(0), .PIPE_DEPTH(4), .NONCE_STRIDE(1), .GN_FIFO_DEPTH(4), .STOP_ON_WRAP(1)) u_dut_c (
        .hash_clk(hash_clk), .reset_n(reset_n), .enable(enable), .load(load), .load_nonce(load_nonce),
        .nonce_prefix(1'b0), .bus(bus_c), .gn_count(o_count[2]), .gn_strobe(o_strobe[2]),
        .gn_overflow(o_ovf[2]), .wrapped(o_wrap[2]), .primed(o_primed[2]));

    // Per-configuration parameters of the reference model
    int          P_CW   [3] = '{29, 29, 32};
    int          P_D    [3] = '{32, 8, 4};
    int          P_S    [3] = '{1, 4, 1};
    int          P_STOP [3] = '{0, 0, 1};
    longint unsigned P_PFX [3] = '{5, 5, 0};

    longint unsigned m_cnt     [3];
    bit              m_halt    [3];
    bit              m_wrapped [3];
    bit              m_ovf     [3];
    bit              m_strobe  [3];
    longint unsigned m_hist    [3][$];
    longint unsigned m_fifo    [3][$];

    function automatic longint unsigned modv(int k);
        return longint'(1) << P_CW[k];
    endfunction

    function automatic longint unsigned mnonce(int k, longint unsigned c);
        return (P_CW[k] == 32) ? c : ((P_PFX[k] << P_CW[k]) | c);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_cnt[k]     = 0;
            m_halt[k]    = 0;
            m_wrapped[k] = 0;
            m_ovf[k]     = 0;
            m_strobe[k]  = 0;
            m_hist[k].delete();
            m_fifo[k].delete();
        end
    endtask

    task automatic model_step(int k);
        bit              is_primed;
        bit              cap;
        longint unsigned cand;
        longint unsigned nxt;
        is_primed = (m_hist[k].size() == P_D[k]);
        cap       = is_primed && gn_match && !load;
        cand      = is_primed ? m_hist[k][0] : 0;
        if (gn_ready && m_fifo[k].size() > 0) void'(m_fifo[k].pop_front());
        m_strobe[k] = cap;
        if (cap) begin
            if (m_fifo[k].size() < 4) m_fifo[k].push_back(cand);
            else m_ovf[k] = 1;
        end
        if (load) begin
            m_cnt[k]     = longint'(load_nonce) % modv(k);
            m_halt[k]    = 0;
            m_wrapped[k] = 0;
            m_ovf[k]     = 0;
            m_hist[k].delete();
        end else if (enable && !m_halt[k]) begin
            m_hist[k].push_back(mnonce(k, m_cnt[k]));
            if (m_hist[k].size() > P_D[k]) void'(m_hist[k].pop_front());
            nxt = m_cnt[k] + longint'(P_S[k]);
            if (nxt >= modv(k)) begin
                m_wrapped[k] = 1;
                if (P_STOP[k] != 0) begin
                    m_halt[k] = 1;
                    m_hist[k].delete();
                end
            end
            m_cnt[k] = nxt % modv(k);
        end else begin
            m_hist[k].delete();
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("nonce_out[%0d]", k), o_nonce[k], mnonce(k, m_cnt[k]));
            chk($sformatf("gn_valid[%0d]", k), o_valid[k], m_fifo[k].size() > 0);
            chk($sformatf("gn_data[%0d]", k), o_data[k], (m_fifo[k].size() > 0) ? m_fifo[k][0] : 0);
            chk($sformatf("gn_count[%0d]", k), o_count[k], m_fifo[k].size());
            chk($sformatf("gn_strobe[%0d]", k), o_strobe[k], m_strobe[k]);
            chk($sformatf("gn_overflow[%0d]", k), o_ovf[k], m_ovf[k]);
            chk($sformatf("wrapped[%0d]", k), o_wrap[k], m_wrapped[k]);
            chk($sformatf("primed[%0d]", k), o_primed[k], m_hist[k].size() == P_D[k]);
        end
    endtask

    task automatic cycle();
        @(posedge hash_clk);
        for (int k = 0; k < 3; k++) model_step(k);
        #1;
        check_all();
    endtask

    initial begin
        logic [31:0] held;
        reset_n = 1'b0; enable = 1'b0; load = 1'b0; load_nonce = '0; gn_match = 1'b0; gn_ready = 1'b0;
        model_reset();
        #2 check_all();
        @(negedge hash_clk);
        reset_n = 1'b1;

        // Default config: prime after 32 advances, back-map a match at 0x140
        load_nonce = 32'h0000_0100; load = 1'b1; enable = 1'b1;
        cycle();
        load = 1'b0;
        chk("t1_load_nonce", o_nonce[0], 32'hA000_0100);
        repeat (31) cycle();
        chk("t1_not_primed_31", o_primed[0], 0);
        cycle();
        chk("t1_primed_32", o_primed[0], 1);
        for (int i = 0; i < 100 && o_nonce[0] != 32'hA000_0140; i++) cycle();
        chk("t1_reach_140", o_nonce[0], 32'hA000_0140);
        chk("t1_empty_before", o_valid[0], 0);
        gn_match = 1'b1;
        cycle();
        gn_match = 1'b0;
        chk("t1_gn_valid", o_valid[0], 1);
        chk("t1_gn_data", o_data[0], 32'hA000_0120);
        chk("t1_strobe", o_strobe[0], 1);
        cycle();
        chk("t1_strobe_single", o_strobe[0], 0);
        chk("t1_count", o_count[0], 1);

        // FIFO overflow, then push+pop while full
        gn_ready = 1'b1;
        cycle();
        gn_ready = 1'b0;
        gn_match = 1'b1;
        repeat (5) cycle();
        gn_match = 1'b0;
        cycle();
        chk("t3_count_full", o_count[0], 4);
        chk("t3_overflow", o_ovf[0], 1);
        gn_match = 1'b1; gn_ready = 1'b1;
        cycle();
        gn_match = 1'b0; gn_ready = 1'b0;
        chk("t3_push_pop_full", o_count[0], 4);
        chk("t3_strobe_full", o_strobe[0], 1);

        // Pause: hold, un-prime, ignore matches until re-primed
        held = o_nonce[0];
        enable = 1'b0; gn_ready = 1'b1;
        repeat (3) cycle();
        chk("t4_hold", o_nonce[0], held);
        chk("t4_unprimed", o_primed[0], 0);
        enable = 1'b1;
        cycle();
        gn_ready = 1'b0;
        chk("t4_drained", o_count[0], 0);
        for (int i = 1; i < 31; i++) begin
            gn_match = (i == 10);
            cycle();
        end
        gn_match = 1'b0;
        chk("t4_still_unprimed", o_primed[0], 0);
        chk("t4_match_ignored", o_count[0], 0);
        cycle();
        chk("t4_reprimed", o_primed[0], 1);
        gn_match = 1'b1;
        cycle();
        gn_match = 1'b0;
        chk("t4_capture_resumed", o_count[0], 1);

        // Prefix + stride 4 + depth 8: wrap and back-map across it
        load_nonce = 32'h1FFF_FFE0; load = 1'b1;
        cycle();
        load = 1'b0; gn_ready = 1'b1;
        chk("t2_wrap_clear", o_wrap[1], 0);
        for (int i = 0; i < 40 && o_nonce[1] != 32'hA000_000C; i++) cycle();
        chk("t2_reach_0c", o_nonce[1], 32'hA000_000C);
        chk("t2_wrapped", o_wrap[1], 1);
        gn_ready = 1'b0; gn_match = 1'b1;
        cycle();
        gn_match = 1'b0;
        chk("t2_capture", o_data[1], 32'hBFFF_FFEC);

        // Stop-on-wrap with full 32-bit counter
        load_nonce = 32'hFFFF_FFFE; load = 1'b1;
        cycle();
        load = 1'b0;
        repeat (5) cycle();
        chk("t5_halted", o_nonce[2], 0);
        chk("t5_wrapped", o_wrap[2], 1);
        chk("t5_unprimed", o_primed[2], 0);
        load_nonce = 32'h0000_0010; load = 1'b1;
        cycle();
        load = 1'b0;
        chk("t5_reload", o_nonce[2], 32'h10);
        chk("t5_wrap_clear", o_wrap[2], 0);
        cycle();
        chk("t5_resume", o_nonce[2], 32'h11);

        // Randomised traffic against the model
        for (int i = 0; i < 1500; i++) begin
            enable     = ($urandom_range(15) != 0);
            load       = ($urandom_range(199) == 0);
            load_nonce = ($urandom_range(1) != 0) ? $urandom : (32'hFFFF_FFC0 | $urandom_range(63));
            gn_match   = ($urandom_range(3) == 0);
            gn_ready   = ($urandom_range(2) == 0);
            cycle();
        end

        // Async reset with two entries queued
        enable = 1'b1; gn_match = 1'b0; gn_ready = 1'b1; load_nonce = '0; load = 1'b1;
        cycle();
        load = 1'b0;
        repeat (40) cycle();
        gn_ready = 1'b0; gn_match = 1'b1;
        repeat (2) cycle();
        gn_match = 1'b0;
        cycle();
        chk("t6_two_entries", o_count[0], 2);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("t6_valid_clear", o_valid[0], 0);
        chk("t6_nonce_clear", o_nonce[0], 32'hA000_0000);
        @(negedge hash_clk);
        reset_n = 1'b1;
        cycle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
